data_mem_responder: RTL and testbench

//  Target (responder) end of the CPU data-memory port: accepts one read or write request at a time

---
 rtl/dmr_pkg.sv | 27 ++
 rtl/dmr_storage.sv | 32 +++
 rtl/data_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmr_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// default widths and the wait-state counter type.
package dmr_pkg;

    localparam int DMR_ADDR_W      = 8;
    localparam int DMR_DATA_W      = 8;
    localparam int DMR_DEPTH       = 256;
    localparam int DMR_WAIT_CYCLES = 1;
    localparam int DMR_CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmr_state_t;

    typedef logic [DMR_CNT_W-1:0] dmr_cnt_t;

    // Counter preload on request acceptance; zero wait states never use the counter.
    function automatic dmr_cnt_t wait_load(input int wait_cycles);
        if (wait_cycles == 0) begin
            return '0;
        end
        return dmr_cnt_t'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/dmr_storage.sv
// DEPTH x DATA_W storage array: synchronous write, registered read, no reset.
// The read register only changes when re is asserted, so its value is held
// for as long as the owner needs it.
module dmr_storage #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_array [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    // Single port: write and read strobes are never raised together.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[idx] <= wdata;
        end
        if (re) begin
            rd_data_reg <= mem_array[idx];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one read/write request at a time, inserts
// WAIT_CYCLES wait states, commits to storage on entry to RESP and holds the
// response until the initiator takes it.
// Optional feature macro: DMR_ADDR_CHECK_EN (out-of-range addresses flag
// resp_err and suppress the access instead of wrapping).
module data_mem_responder
    import dmr_pkg::*;
#(
    parameter int ADDR_W      = DMR_ADDR_W,
    parameter int DATA_W      = DMR_DATA_W,
    parameter int DEPTH       = DMR_DEPTH,
    parameter int WAIT_CYCLES = DMR_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    dmr_state_t        state_reg, state_next;
    dmr_cnt_t          cnt_reg, cnt_next;

    logic              lat_write_reg;
    logic [ADDR_W-1:0] lat_addr_reg;
    logic [DATA_W-1:0] lat_wdata_reg;

    logic              resp_is_read_reg, resp_is_read_next;
    logic              resp_err_reg, resp_err_next;

    logic              accept;
    logic              enter_resp;
    logic              commit_write;
    logic [ADDR_W-1:0] commit_addr;
    logic [DATA_W-1:0] commit_wdata;
    logic              addr_err;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rd_data;

    // With zero wait states RESP is entered on the accepting edge itself, so
    // the commit must use the live request; otherwise the latched copy.
    always_comb begin
        commit_write = lat_write_reg;
        commit_addr  = lat_addr_reg;
        commit_wdata = lat_wdata_reg;
        if (state_reg == IDLE) begin
            commit_write = req_write;
            commit_addr  = req_addr;
            commit_wdata = req_wdata;
        end
    end

`ifdef DMR_ADDR_CHECK_EN
    // Anything at or beyond DEPTH is an error rather than an alias.
    assign addr_err = ({1'b0, commit_addr} >= (ADDR_W + 1)'(DEPTH));
`else
    // Upper address bits are deliberately dropped: addresses wrap modulo DEPTH.
    logic unused_addr_bits;
    assign unused_addr_bits = ^commit_addr;
    assign addr_err         = 1'b0;
`endif

    // Next-state, counter and response-flag logic.
    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        accept            = 1'b0;
        enter_resp        = 1'b0;
        resp_is_read_next = resp_is_read_reg;
        resp_err_next     = resp_err_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = wait_load(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg - dmr_cnt_t'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next        = IDLE;
                    resp_is_read_next = 1'b0;
                    resp_err_next     = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (enter_resp) begin
            resp_is_read_next = !commit_write && !addr_err;
            resp_err_next     = addr_err;
        end
    end

    // Storage strobes are gated by reset so an abandoned write is never committed.
    always_comb begin
        mem_we = 1'b0;
        mem_re = 1'b0;
        if (enter_resp && rst && !addr_err) begin
            mem_we = commit_write;
            mem_re = !commit_write;
        end
    end

    // State register, wait counter, request latches and response flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            lat_write_reg    <= 1'b0;
            lat_addr_reg     <= '0;
            lat_wdata_reg    <= '0;
            resp_is_read_reg <= 1'b0;
            resp_err_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            resp_is_read_reg <= resp_is_read_next;
            resp_err_reg     <= resp_err_next;
            if (accept) begin
                lat_write_reg <= req_write;
                lat_addr_reg  <= req_addr;
                lat_wdata_reg <= req_wdata;
            end
        end
    end

    dmr_storage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_storage (
        .clk     (clk),
        .we      (mem_we),
        .re      (mem_re),
        .idx     (commit_addr[IDX_W-1:0]),
        .wdata   (commit_wdata),
        .rd_data (mem_rd_data)
    );

    // The read register has no reset, so the visible data is forced to zero
    // whenever the current response is not a successful read.
    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = resp_is_read_reg ? mem_rd_data : '0;
    assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT_CYCLES 1/0/3, DEPTH
// 256/128/128) share one clock and reset. A transaction-level model predicts
// every output on every cycle; directed transactions add literal checks.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid  [3];
    logic       req_ready  [3];
    logic       req_write  [3];
    logic [7:0] req_addr   [3];
    logic [7:0] req_wdata  [3];
    logic       resp_valid [3];
    logic       resp_ready [3];
    logic [7:0] resp_rdata [3];
    logic       resp_err   [3];

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int pcyc  = 0;

    function automatic int wait_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 256 : 128;
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            data_mem_responder #(
                .ADDR_W      (8),
                .DATA_W      (8),
                .DEPTH       (depth_of(gi)),
                .WAIT_CYCLES (wait_of(gi))
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .req_valid  (req_valid[gi]),
                .req_ready  (req_ready[gi]),
                .req_write  (req_write[gi]),
                .req_addr   (req_addr[gi]),
                .req_wdata  (req_wdata[gi]),
                .resp_valid (resp_valid[gi]),
                .resp_ready (resp_ready[gi]),
                .resp_rdata (resp_rdata[gi]),
                .resp_err   (resp_err[gi])
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected response", name);
    endtask

    always @(posedge clk) pcyc <= pcyc + 1;

    // ---------------- transaction-level model ----------------
    // A request seen at cycle n is answered from cycle n+1+W until taken;
    // the access takes effect when the answer first becomes visible, so an
    // access abandoned by reset before then never happens.
    bit         armed    [3];
    bit         busy     [3];
    bit         applied  [3];
    int         acc      [3];
    bit         op_w     [3];
    logic [7:0] op_a     [3];
    logic [7:0] op_d     [3];
    logic [7:0] exp_rd   [3];
    bit         exp_er   [3];
    bit         rd_known [3];
    logic [7:0] mmem     [3][256];
    bit         known    [3][256];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bit vis;
            bit oor;
            int idx;
            vis = busy[k] && (cyc_n >= acc[k] + 1 + wait_of(k));
            if (armed[k]) begin
                if (vis && !applied[k]) begin
                    idx = int'(op_a[k]) % depth_of(k);
`ifdef DMR_ADDR_CHECK_EN
                    oor = (int'(op_a[k]) >= depth_of(k));
`else
                    oor = 1'b0;
`endif
                    exp_er[k]   = oor;
                    exp_rd[k]   = 8'h00;
                    rd_known[k] = 1'b1;
                    if (op_w[k]) begin
                        if (!oor) begin
                            mmem[k][idx]  = op_d[k];
                            known[k][idx] = 1'b1;
                        end
                    end else if (!oor) begin
                        exp_rd[k]   = mmem[k][idx];
                        rd_known[k] = known[k][idx];
                    end
                    applied[k] = 1'b1;
                end
                chk($sformatf("req_ready[%0d]@%0d", k, cyc_n), 32'(req_ready[k]), 32'(!busy[k]));
                chk($sformatf("resp_valid[%0d]@%0d", k, cyc_n), 32'(resp_valid[k]), 32'(vis));
                chk($sformatf("resp_err[%0d]@%0d", k, cyc_n), 32'(resp_err[k]), 32'(vis && exp_er[k]));
                if (!vis || rd_known[k]) begin
                    chk($sformatf("resp_rdata[%0d]@%0d", k, cyc_n), 32'(resp_rdata[k]),
                        vis ? 32'(exp_rd[k]) : 32'd0);
                end
            end
            if (rst === 1'b0) begin
                armed[k] = 1'b1;
                busy[k]  = 1'b0;
            end else if (armed[k]) begin
                if (!busy[k] && req_valid[k]) begin
                    busy[k]    = 1'b1;
                    acc[k]     = cyc_n;
                    applied[k] = 1'b0;
                    op_w[k]    = req_write[k];
                    op_a[k]    = req_addr[k];
                    op_d[k]    = req_wdata[k];
                end else if (vis && resp_ready[k]) begin
                    busy[k] = 1'b0;
                end
            end
        end
        cyc_n++;
    end

    // ---------------- directed stimulus ----------------
    // One transaction on instance k. hold>0 keeps resp_ready low for hold
    // cycles in RESP while a stray write request is presented.
    task automatic txn(input int k, input bit w, input logic [7:0] a, input logic [7:0] d,
                       input int hold, output logic [7:0] rd, output bit er,
                       output int lat, output int acc_at);
        int n;
        @(posedge clk); #1;
        req_valid[k]  = 1'b1;
        req_write[k]  = w;
        req_addr[k]   = a;
        req_wdata[k]  = d;
        resp_ready[k] = (hold == 0);
        n = 0;
        @(negedge clk);
        while (req_ready[k] !== 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) fail_now("accept_timeout");
        @(posedge clk); #1;
        acc_at       = pcyc;
        req_valid[k] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (resp_valid[k] !== 1'b1 && lat < 40);
        if (lat >= 40) fail_now("resp_timeout");
        rd = resp_rdata[k];
        er = resp_err[k];
        if (hold > 0) begin
            @(posedge clk); #1;
            req_valid[k] = 1'b1;
            req_write[k] = 1'b1;
            req_addr[k]  = a ^ 8'h01;
            req_wdata[k] = 8'hEE;
            repeat (hold - 1) @(posedge clk);
            @(posedge clk); #1;
            req_valid[k]  = 1'b0;
            resp_ready[k] = 1'b1;
        end
        $display("txn dut%0d %s addr=%02h wdata=%02h -> rdata=%02h err=%0d lat=%0d",
                 k, w ? "WR" : "RD", a, d, rd, er, lat);
    endtask

    // Accept a write on instance k, then reset before it can commit.
    task automatic aborted_write(input int k, input logic [7:0] a, input logic [7:0] d,
                                 input int delay);
        @(posedge clk); #1;
        req_valid[k] = 1'b1;
        req_write[k] = 1'b1;
        req_addr[k]  = a;
        req_wdata[k] = d;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        repeat (delay) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        $display("txn dut%0d WR addr=%02h wdata=%02h aborted by reset", k, a, d);
    endtask

    logic [7:0] rd;
    bit         er;
    int         lat, a1, a2;

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid[k]  = 1'b0;
            req_write[k]  = 1'b0;
            req_addr[k]   = 8'h00;
            req_wdata[k]  = 8'h00;
            resp_ready[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_req_ready%0d", k), 32'(req_ready[k]), 32'd1);
            chk($sformatf("reset_resp_valid%0d", k), 32'(resp_valid[k]), 32'd0);
            chk($sformatf("reset_rdata%0d", k), 32'(resp_rdata[k]), 32'd0);
            chk($sformatf("reset_err%0d", k), 32'(resp_err[k]), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;

        // WAIT_CYCLES=1: write then read back
        txn(0, 1'b1, 8'h10, 8'h3C, 0, rd, er, lat, a1);
        chk("w1_write_lat", 32'(lat), 32'd2);
        chk("w1_write_rdata", 32'(rd), 32'h00);
        txn(0, 1'b0, 8'h10, 8'h00, 0, rd, er, lat, a1);
        chk("w1_read_rdata", 32'(rd), 32'h3C);
        chk("w1_read_lat", 32'(lat), 32'd2);

        // Backpressure with a stray write to 0x11 that must be ignored
        txn(0, 1'b1, 8'h11, 8'h5A, 0, rd, er, lat, a1);
        txn(0, 1'b0, 8'h10, 8'h00, 5, rd, er, lat, a1);
        chk("bp_rdata", 32'(rd), 32'h3C);
        txn(0, 1'b0, 8'h11, 8'h00, 0, rd, er, lat, a1);
        chk("bp_stray_ignored", 32'(rd), 32'h5A);

        // WAIT_CYCLES=0: latency 1, back-to-back spacing 2
        txn(1, 1'b1, 8'h20, 8'h42, 0, rd, er, lat, a1);
        txn(1, 1'b0, 8'h20, 8'h00, 0, rd, er, lat, a1);
        chk("w0_read_rdata", 32'(rd), 32'h42);
        chk("w0_read_lat", 32'(lat), 32'd1);
        txn(1, 1'b0, 8'h20, 8'h00, 0, rd, er, lat, a2);
        chk("w0_spacing", 32'(a2 - a1), 32'd2);

        // WAIT_CYCLES=3: latency 4, back-to-back spacing 5
        txn(2, 1'b1, 8'h30, 8'h99, 0, rd, er, lat, a1);
        txn(2, 1'b0, 8'h30, 8'h00, 0, rd, er, lat, a1);
        chk("w3_read_rdata", 32'(rd), 32'h99);
        chk("w3_read_lat", 32'(lat), 32'd4);
        txn(2, 1'b0, 8'h30, 8'h00, 0, rd, er, lat, a2);
        chk("w3_spacing", 32'(a2 - a1), 32'd5);

        // Reset mid-WAIT abandons the write
        txn(2, 1'b1, 8'h05, 8'h11, 0, rd, er, lat, a1);
        aborted_write(2, 8'h05, 8'hAA, 1);
        txn(2, 1'b0, 8'h05, 8'h00, 0, rd, er, lat, a1);
        chk("w3_abort_rdata", 32'(rd), 32'h11);
        // Reset landing on the would-be commit edge
        txn(0, 1'b1, 8'h05, 8'h11, 0, rd, er, lat, a1);
        aborted_write(0, 8'h05, 8'hAA, 0);
        txn(0, 1'b0, 8'h05, 8'h00, 0, rd, er, lat, a1);
        chk("w1_abort_rdata", 32'(rd), 32'h11);
        chk("w1_abort_err", 32'(er), 32'd0);

        // DEPTH=128: address 0x85 either errors or aliases 0x05
        for (int k = 1; k < 3; k++) begin
            txn(k, 1'b1, 8'h05, 8'h11, 0, rd, er, lat, a1);
            txn(k, 1'b1, 8'h85, 8'h77, 0, rd, er, lat, a1);
`ifdef DMR_ADDR_CHECK_EN
            chk($sformatf("oor_err%0d", k), 32'(er), 32'd1);
            txn(k, 1'b0, 8'h05, 8'h00, 0, rd, er, lat, a1);
            chk($sformatf("oor_alias%0d", k), 32'(rd), 32'h11);
`else
            chk($sformatf("oor_err%0d", k), 32'(er), 32'd0);
            txn(k, 1'b0, 8'h05, 8'h00, 0, rd, er, lat, a1);
            chk($sformatf("oor_alias%0d", k), 32'(rd), 32'h77);
`endif
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
